// File: rtl/mc_control_unit.sv
// Multicycle control unit: Moore-style sequencer for a 16-bit multicycle datapath.
// Decodes opcode/funct into datapath controls, one micro-step per clock.
module mc_control_unit #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         opcode,
  input  logic [2:0]         funct,
  input  logic               zero,
  output logic               PCEn,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUControl,
  output logic               PCSrc,
  output logic [STATE_W-1:0] state,
  output logic               instr_done,
  output logic               illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10
  } state_e;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_LW    = 4'b0010;
  localparam logic [3:0] OP_SW    = 4'b0011;
  localparam logic [3:0] OP_BEQ   = 4'b0100;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_ONE    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  state_e state_q, state_d;
  state_e dec_state;
  logic   pc_write;
  logic   branch;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values; blocking here would create ordering-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic; opcode only matters in DECODE and MEMADR
  // ---------------------------------------------------------------------------
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: state_d = S_EXEC;
          OP_ADDI:  state_d = S_ADDIEX;
          OP_LW,
          OP_SW:    state_d = S_MEMADR;
          OP_BEQ:   state_d = S_BRANCH;
          default:  state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB,
      S_MEMWR,
      S_ALUWB,
      S_BRANCH,
      S_ADDIWB: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // While reset is held the decoder presents FETCH so the datapath muxes
  // already point at the PC; the strobes are masked further below.
  always_comb begin
    dec_state = rst ? S_FETCH : state_q;
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_write   = 1'b0;
    branch     = 1'b0;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    ALUControl = ALU_ADD;
    PCSrc      = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;

    case (dec_state)
      S_FETCH: begin
        IRWrite  = 1'b1;
        ALUSrcB  = SRCB_ONE;
        pc_write = 1'b1;
      end
      S_DECODE: begin
        // Branch target is precomputed here and parked in ALUOut.
        ALUSrcB = SRCB_BRANCH;
        case (opcode)
          OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ: illegal_op = 1'b0;
          default:                                 illegal_op = 1'b1;
        endcase
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        IorD = 1'b1;
      end
      S_MEMWR: begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_ADDIWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        case (funct)
          3'b000:  ALUControl = ALU_ADD;
          3'b001:  ALUControl = ALU_SUB;
          3'b010:  ALUControl = ALU_AND;
          3'b011:  ALUControl = ALU_OR;
          3'b100:  ALUControl = ALU_SLT;
          default: ALUControl = ALU_ADD;
        endcase
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = 1'b1;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      default: begin
        pc_write = 1'b0;
      end
    endcase

    PCEn = pc_write | (branch & zero);

    if (rst) begin
      PCEn       = 1'b0;
      IRWrite    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
    end
  end

  assign state = state_q;

endmodule
